// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Holds funct3 codes, window defaults and the window range check.
package data_mem_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RAM_RSP,
      FB_WAIT,
      FB_RSP,
      ERR
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_0000;
   localparam logic [31:0] FB_BASE_DEF   = 32'h8000_0000;
   localparam int unsigned RAM_WORDS_DEF = 1024;
   localparam int unsigned FB_WORDS_DEF  = 19200;

   // Wraparound below base yields a huge index, so it falls out of range.
   function automatic logic in_window(
      input logic [31:0] addr,
      input logic [31:0] base,
      input logic [31:0] words
   );
      logic [31:0] off;
      off = addr - base;
      return {2'b00, off[31:2]} < words;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage load/store bus between processor, responder and GPU.
// slave is the responder side, master the processor/GPU side.
interface data_mem_responder_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [2:0]  req_funct3_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_error_o;
   logic        fb_valid_o;
   logic        fb_ready_i;
   logic [31:0] fb_addr_o;
   logic [31:0] fb_wdata_o;
   logic [3:0]  fb_be_o;
   logic        busy_o;

   modport slave (
      input  req_valid_i,
      output req_ready_o,
      input  req_write_i,
      input  req_addr_i,
      input  req_wdata_i,
      input  req_funct3_i,
      output rsp_valid_o,
      output rsp_rdata_o,
      output rsp_error_o,
      output fb_valid_o,
      input  fb_ready_i,
      output fb_addr_o,
      output fb_wdata_o,
      output fb_be_o,
      output busy_o
   );

   modport master (
      output req_valid_i,
      input  req_ready_o,
      output req_write_i,
      output req_addr_i,
      output req_wdata_i,
      output req_funct3_i,
      input  rsp_valid_o,
      input  rsp_rdata_o,
      input  rsp_error_o,
      input  fb_valid_o,
      output fb_ready_i,
      input  fb_addr_o,
      input  fb_wdata_o,
      input  fb_be_o,
      input  busy_o
   );

endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Lane select and sign/zero extension of a RAM word for loads.
// Illegal size codes return zero.
module load_extend
   import data_mem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[7:0];
      unique case (lane)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         2'd3: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      data = '0;
      unique case (funct3)
         F3_B:    data = {{24{b[7]}}, b};
         F3_BU:   data = {24'b0, b};
         F3_H:    data = {{16{h[15]}}, h};
         F3_HU:   data = {16'b0, h};
         F3_W:    data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: internal RAM for loads/stores plus a
// write-only framebuffer window forwarded to the GPU.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
   parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
   parameter logic [31:0] FB_BASE   = FB_BASE_DEF,
   parameter int unsigned FB_WORDS  = FB_WORDS_DEF
) (
   input logic clk_i,
   input logic reset_i,
   data_mem_responder_if.slave bus
);

   localparam int AW = $clog2(RAM_WORDS);

   mem_state_t state, state_n;

   logic [31:0] addr;
   logic [2:0]  f3;
   logic        wr;
   logic        f3_ok;
   logic        mis;
   logic        in_ram;
   logic        in_fb;
   logic        err;
   logic        accept;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] ram_off;
   logic [31:0] fb_off;
   logic [AW-1:0] ram_idx;
   logic        ram_en;
   logic        ram_we;
   logic        unused_bits;

   logic [31:0] mem [RAM_WORDS];
   logic [31:0] rd_q;
   logic [1:0]  lane_q;
   logic [2:0]  f3_q;
   logic        load_q;
   logic [31:0] fb_addr_q;
   logic [31:0] fb_wdata_q;
   logic [3:0]  fb_be_q;
   logic [31:0] ext;

   assign addr = bus.req_addr_i;
   assign f3   = bus.req_funct3_i;
   assign wr   = bus.req_write_i;

   always_comb begin
      f3_ok = 1'b0;
      unique case (f3)
         F3_B, F3_H, F3_W: f3_ok = 1'b1;
         F3_BU, F3_HU:     f3_ok = !wr;
         default:          f3_ok = 1'b0;
      endcase
   end

   assign mis = (f3[1:0] == 2'b01 && addr[0])
              | (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);

   assign in_ram = in_window(addr, RAM_BASE, RAM_WORDS);
   assign in_fb  = in_window(addr, FB_BASE, FB_WORDS);

   // The framebuffer is write-only, so a load there is an error.
   assign err = !f3_ok | mis | (!in_ram & !(in_fb & wr));

   assign accept = bus.req_valid_i & (state == IDLE) & !reset_i;

   always_comb begin
      be = 4'b0000;
      wd = bus.req_wdata_i;
      unique case (1'b1)
         f3[1:0] == 2'b00: begin
            be = 4'b0001 << addr[1:0];
            wd = {4{bus.req_wdata_i[7:0]}};
         end
         f3[1:0] == 2'b01: begin
            be = addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{bus.req_wdata_i[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   assign ram_off = addr - RAM_BASE;
   assign fb_off  = addr - FB_BASE;
   assign ram_idx = ram_off[AW+1:2];
   assign ram_en  = accept & !err & in_ram;
   assign ram_we  = ram_en & wr;

   assign unused_bits = ^{ram_off[31:AW+2], ram_off[1:0], fb_off[1:0]};

   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[ram_idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
      if (ram_en) rd_q <= mem[ram_idx];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (err)         state_n = ERR;
               else if (in_ram) state_n = RAM_RSP;
               else             state_n = FB_WAIT;
            end
         end
         FB_WAIT: if (bus.fb_ready_i) state_n = FB_RSP;
         RAM_RSP, FB_RSP, ERR: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lane_q     <= '0;
         f3_q       <= '0;
         load_q     <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
         fb_be_q    <= '0;
      end else if (accept) begin
         lane_q <= addr[1:0];
         f3_q   <= f3;
         load_q <= !wr;
         if (!err && !in_ram) begin
            fb_addr_q  <= {2'b00, fb_off[31:2]};
            fb_wdata_q <= wd;
            fb_be_q    <= be;
         end
      end
   end

   load_extend u_ext (
      .word   (rd_q),
      .lane   (lane_q),
      .funct3 (f3_q),
      .data   (ext)
   );

   assign bus.req_ready_o = (state == IDLE);
   assign bus.busy_o      = (state != IDLE);
   assign bus.fb_valid_o  = (state == FB_WAIT);
   assign bus.fb_addr_o   = fb_addr_q;
   assign bus.fb_wdata_o  = fb_wdata_q;
   assign bus.fb_be_o     = fb_be_q;
   assign bus.rsp_valid_o = (state == RAM_RSP) | (state == FB_RSP)
                          | (state == ERR);
   assign bus.rsp_error_o = (state == ERR);
   assign bus.rsp_rdata_o = (state == RAM_RSP && load_q) ? ext : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-level reference memory,
// GPU responder model with random stalls, and a response monitor.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam logic [31:0] FBB = 32'h8000_0000;
   localparam int unsigned RW  = 1024;
   localparam int unsigned FW  = 19200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_mem_responder_if bus();

   data_mem_responder dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [31:0] idx;
      logic [31:0] data;
      logic [3:0]  be;
   } fbw_t;

   rsp_t rsp_q[$];
   fbw_t fb_q[$];
   logic [7:0] ref_mem [bit [31:0]];

   int gpu_delay = 0;
   bit gpu_hold = 0;
   int gpu_cnt = 0;
   int hs_cyc = -10;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: byte-addressed memory, little-endian, rules straight
   // from the size/sign/alignment/window definitions.
   task automatic model(
      input  bit          wr,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      input  logic [2:0]  f3,
      output bit          err,
      output bit          to_fb,
      output logic [31:0] rd
   );
      int size;
      bit sgn;
      bit legal;
      bit in_r;
      bit in_f;
      logic [31:0] df;
      fbw_t w;
      size = 1; sgn = 0; legal = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; legal = 1; end
         3'd1: begin size = 2; sgn = 1; legal = 1; end
         3'd2: begin size = 4; sgn = 0; legal = 1; end
         3'd4: begin size = 1; sgn = 0; legal = !wr; end
         3'd5: begin size = 2; sgn = 0; legal = !wr; end
         default: legal = 0;
      endcase
      in_r = (a / 4) < RW;
      df = a - FBB;
      in_f = (df / 4) < FW;
      err = !legal || (a % size) != 0 || !(in_r || (in_f && wr));
      to_fb = !err && !in_r;
      rd = '0;
      if (!err && in_r) begin
         if (wr) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[a + i];
            if (sgn && size < 4 && rd[8*size-1])
               rd = rd | (32'hFFFF_FFFF << (8*size));
         end
      end
      if (to_fb) begin
         w.idx  = df / 4;
         w.be   = 4'((1 << size) - 1) << a[1:0];
         w.data = (size == 1) ? {4{wd[7:0]}}
                : (size == 2) ? {2{wd[15:0]}} : wd;
         fb_q.push_back(w);
      end
   endtask

   task automatic drive(input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output bit tofb);
      bit err;
      logic [31:0] rd;
      rsp_t e;
      check("req_ready", 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i  = 1'b1;
      bus.req_write_i  = wr;
      bus.req_addr_i   = a;
      bus.req_wdata_i  = wd;
      bus.req_funct3_i = f3;
      model(wr, a, wd, f3, err, tofb, rd);
      e.rdata = rd;
      e.err = err;
      rsp_q.push_back(e);
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
   endtask

   task automatic req(input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input bit now = 0);
      bit tofb;
      int n;
      if (!now) @(negedge clk);
      drive(wr, a, wd, f3, tofb);
      @(negedge clk);
      if (!tofb) begin
         check("rsp_latency", 32'(bus.rsp_valid_o), 32'd1);
      end else begin
         n = 0;
         while (!bus.rsp_valid_o && n < 60) begin
            check("busy_fb_wait", 32'(bus.busy_o), 32'd1);
            @(negedge clk);
            n++;
         end
         check("fb_rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
         check("fb_rsp_latency", cyc, hs_cyc + 1);
         check("busy_at_rsp", 32'(bus.busy_o), 32'd1);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_ctl"}, 32'({bus.req_ready_o, bus.rsp_valid_o,
            bus.rsp_error_o, bus.fb_valid_o, bus.busy_o}), 32'b10000);
      check({tag, "_rdata"}, bus.rsp_rdata_o, 32'd0);
      check({tag, "_fb_addr"}, bus.fb_addr_o, 32'd0);
      check({tag, "_fb_wdata"}, bus.fb_wdata_o, 32'd0);
      check({tag, "_fb_be"}, 32'(bus.fb_be_o), 32'd0);
   endtask

   // Response monitor
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rsp_valid with empty queue");
            end else begin
               e = rsp_q.pop_front();
               check("rsp_error", 32'(bus.rsp_error_o), 32'(e.err));
               check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
            end
         end
      end
   end

   // GPU side: checks held write contents each cycle, stalls gpu_delay cycles
   initial begin
      bus.fb_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.fb_ready_i = 1'b0;
            gpu_cnt = 0;
         end else if (bus.fb_ready_i) begin
            bus.fb_ready_i = 1'b0;
         end else if (bus.fb_valid_o) begin
            if (fb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL fb_unexpected: got fb_valid addr %h expected none",
                        bus.fb_addr_o);
            end else begin
               check("fb_addr", bus.fb_addr_o, fb_q[0].idx);
               check("fb_wdata", bus.fb_wdata_o, fb_q[0].data);
               check("fb_be", 32'(bus.fb_be_o), 32'(fb_q[0].be));
               gpu_cnt++;
               if (!gpu_hold && gpu_cnt > gpu_delay) begin
                  bus.fb_ready_i = 1'b1;
                  hs_cyc = cyc;
                  gpu_cnt = 0;
                  void'(fb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] edges [6];
      logic [31:0] a;
      bit wr;
      bit tofb;
      int r;
      edges[0] = 32'h0000_0FFC;
      edges[1] = 32'h0000_1000;
      edges[2] = 32'h0000_1004;
      edges[3] = 32'hFFFF_FFFC;
      edges[4] = FBB + FW * 4;
      edges[5] = FBB - 4;

      bus.req_valid_i  = 1'b0;
      bus.req_write_i  = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_wdata_i  = '0;
      bus.req_funct3_i = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int w = 0; w < 64; w++) req(1, 32'(w * 4), $urandom, F3_W);
      req(1, 32'h0000_0FFC, $urandom, F3_W);

      req(1, 32'h10, 32'hDEAD_BEEF, F3_W);
      req(0, 32'h10, 32'h0, F3_W);
      req(1, 32'h13, 32'h0000_0080, F3_B);
      req(0, 32'h13, 32'h0, F3_B);
      req(0, 32'h13, 32'h0, F3_BU);
      req(0, 32'h12, 32'h0, F3_H);
      req(0, 32'h12, 32'h0, F3_HU);
      req(0, 32'h11, 32'h0, F3_W);
      req(1, 32'h21, 32'h1234_5678, F3_H);
      req(0, 32'h20, 32'h0, F3_W);
      req(0, 32'h0000_1000, 32'h0, F3_W);
      req(0, 32'h0000_0FFC, 32'h0, F3_W);
      gpu_delay = 3;
      req(1, FBB + 8, 32'h00FF_00FF, F3_W);
      gpu_delay = 0;
      req(1, FBB + 5, 32'h0000_00A5, F3_B);
      req(1, FBB + 4 * (FW - 1) + 2, 32'h0000_BEEF, F3_H);
      req(0, FBB, 32'h0, F3_W);
      req(0, 32'h10, 32'h0, 3'b011);
      req(1, 32'h10, 32'h0, F3_BU);

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         wr = 1'($urandom_range(0, 1));
         if (r < 6) a = 32'($urandom_range(0, 255));
         else if (r == 6) a = edges[$urandom_range(0, 5)];
         else if (r < 9) begin
            wr = ($urandom_range(0, 3) != 0);
            a = (r == 7) ? FBB + 32'($urandom_range(0, 79))
                         : FBB + FW * 4 - 8 + 32'($urandom_range(0, 15));
         end else a = $urandom;
         gpu_delay = $urandom_range(0, 4);
         req(wr, a, $urandom, 3'($urandom_range(0, 7)));
      end

      // Reset while a framebuffer write is stalled
      gpu_hold = 1;
      gpu_delay = 0;
      @(negedge clk);
      drive(1, FBB + 4, 32'hCAFE_F00D, F3_W, tofb);
      repeat (2) @(negedge clk);
      check("fb_held_before_reset", 32'(bus.fb_valid_o), 32'd1);
      #2;
      rst = 1'b1;
      rsp_q.delete();
      fb_q.delete();
      @(negedge clk);
      check_reset_outputs("mid_reset");
      rst = 1'b0;
      gpu_hold = 0;
      req(0, 32'h10, 32'h0, F3_W, 1);
      req(1, FBB + 12, 32'h0102_0304, F3_W);

      repeat (5) @(negedge clk);
      check("rsp_q_drained", rsp_q.size(), 32'd0);
      check("fb_q_drained", fb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
